// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter, one serial bit per CLK cycle.
//
// Accepts a parallel word on a single-cycle Data_Valid strobe while idle and sends it as a
// start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit and a stop bit (1).
// The word, parity enable and parity type are latched at acceptance, so later changes to
// the inputs never affect a frame in flight. Strobes while busy are dropped, not queued.
//
// Ports:
//   CLK        in   TX baud clock, rising edge
//   RST        in   synchronous active-low reset
//   P_DATA     in   [DATA_WIDTH-1:0] word to send, sampled on an accepted strobe
//   Data_Valid in   single-cycle request strobe, honoured only while idle
//   PAR_EN     in   1 = append a parity bit
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   TX_OUT     out  serial line, idles high, registered
//   Busy       out  high for the whole frame (start..stop), registered

module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    // Counter must be at least one bit wide even for a one-bit word.
    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;     // latched word, kept intact for parity
    logic [DATA_WIDTH-1:0] shift_q, shift_d;   // copy that is shifted out LSB first
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  parity_bit;

    // Even parity is the XOR of the latched word; odd parity is its inverse.
    assign parity_bit = (^data_q) ^ par_typ_q;

    // Next-state logic. The outputs are computed for the state being entered, so that the
    // registered TX_OUT/Busy already show the new state's values right after the edge.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = 1'b1;
        busy_d    = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (Data_Valid) begin
                    state_d   = StStart;
                    data_d    = P_DATA;
                    shift_d   = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end

            StStart: begin
                state_d   = StData;
                bit_cnt_d = '0;
                tx_d      = shift_q[0];
                shift_d   = shift_q >> 1;
            end

            StData: begin
                if (bit_cnt_q == LastBit) begin
                    bit_cnt_d = '0;
                    if (par_en_q) begin
                        state_d = StParity;
                        tx_d    = parity_bit;
                    end else begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end

            StParity: begin
                state_d = StStop;
                tx_d    = 1'b1;
            end

            StStop: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Synchronous reset wins over everything; a frame cut short leaves the line high.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= StIdle;
            data_q    <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx with hand-computed frames.
//
// Frames are written as {stop, [parity], data, start}, read LSB first in line order.

module tb_uart_tx;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int n_pass  = 0;
    int n_total = 0;

    uart_tx #(
        .DATA_WIDTH(8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Advance one edge; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check($sformatf("%s tx[%0d]", tag, i), TX_OUT, 1'b1);
            check($sformatf("%s busy[%0d]", tag, i), Busy, 1'b0);
            tick();
        end
    endtask

    // Strobe a word and check every frame cycle plus the first idle cycle after it.
    // inj >= 0 pulses a 0xFF strobe and flips PAR_EN during frame cycle inj.
    // Returns at the sample point of that first idle cycle with Data_Valid low.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [10:0] exp, input int len,
                             input int inj);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        P_DATA     = ~d;       // must not leak into the frame in flight
        PAR_TYP    = ~pt;
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s tx[%0d]", tag, i), TX_OUT, exp[i]);
            check($sformatf("%s busy[%0d]", tag, i), Busy, 1'b1);
            if (i == inj) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'hFF;
                PAR_EN     = ~pe;
            end else begin
                Data_Valid = 1'b0;
            end
            tick();
        end
        Data_Valid = 1'b0;
        check($sformatf("%s end tx", tag), TX_OUT, 1'b1);
        check($sformatf("%s end busy", tag), Busy, 1'b0);
    endtask

    initial begin
        RST        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #1;

        // Reset held for two edges, then released with no strobe.
        tick();
        check("rst0 tx", TX_OUT, 1'b1);
        check("rst0 busy", Busy, 1'b0);
        tick();
        check("rst1 tx", TX_OUT, 1'b1);
        check("rst1 busy", Busy, 1'b0);
        RST = 1'b1;
        tick();
        check_idle("hold", 5);

        // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1.
        run_frame("nopar_a5", 8'hA5, 1'b0, 1'b0, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, -1);
        tick();
        check_idle("gap1", 2);

        // 0xA5 has four ones: even parity 0, odd parity 1.
        run_frame("even_a5", 8'hA5, 1'b1, 1'b0, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, -1);
        tick();
        run_frame("odd_a5", 8'hA5, 1'b1, 1'b1, {1'b1, 1'b1, 8'hA5, 1'b0}, 11, -1);
        tick();
        run_frame("odd_00", 8'h00, 1'b1, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 11, -1);
        tick();

        // Strobe with 0xFF and PAR_EN flipped during frame cycle 4: ignored entirely.
        run_frame("ign_3c", 8'h3C, 1'b0, 1'b0, {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 4);
        tick();
        check_idle("no_ff", 6);

        // Back-to-back: strobe on the first idle cycle after stop.
        run_frame("b2b_1", 8'h81, 1'b0, 1'b0, {1'b0, 1'b1, 8'h81, 1'b0}, 10, -1);
        run_frame("b2b_2", 8'h7E, 1'b1, 1'b0, {1'b1, 1'b0, 8'h7E, 1'b0}, 11, -1);
        tick();

        // Reset during data bit 3 of 0x5A: bit3 of 0x5A is 1, cycle 4 after the strobe.
        P_DATA     = 8'h5A;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        check("mid start tx", TX_OUT, 1'b0);
        tick();
        check("mid bit0 tx", TX_OUT, 1'b0);
        tick();
        tick();
        tick();
        check("mid bit3 tx", TX_OUT, 1'b1);
        check("mid bit3 busy", Busy, 1'b1);
        RST = 1'b0;
        tick();
        check("mid rst tx", TX_OUT, 1'b1);
        check("mid rst busy", Busy, 1'b0);
        RST = 1'b1;
        check_idle("post_rst", 3);

        // 0xC3 has four ones: odd parity 1.
        run_frame("after_rst", 8'hC3, 1'b1, 1'b1, {1'b1, 1'b1, 8'hC3, 1'b0}, 11, -1);
        tick();
        check_idle("tail", 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: the transmit end of the same serial link whose receive side samples and checks the start bit. Accepts a parallel word with a one-cycle valid strobe and serialises it as start bit, data LSB-first, optional parity bit and stop bit. `CLK` is the TX baud clock, so each serial bit lasts exactly one `CLK` cycle. Sits between the command/response core and the physical TX pin.

## Interface
- `DATA_WIDTH`, 8, width of the parallel data word.
- `CLK`  input  1  TX baud clock; all logic is on the rising edge.
- `RST`  input  1  synchronous, active-low reset.
- `P_DATA`  input  DATA_WIDTH  parallel word to send; sampled only on an accepted strobe.
- `Data_Valid`  input  1  single-cycle request strobe.
- `PAR_EN`  input  1  1 = insert a parity bit.
- `PAR_TYP`  input  1  0 = even parity, 1 = odd parity.
- `TX_OUT`  output  1  serial line; idles high; registered.
- `Busy`  output  1  high while a frame is in progress; registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1, `Busy`=0. `Data_Valid`=1 at a rising edge latches `P_DATA`, `PAR_EN` and `PAR_TYP` into internal registers, then goes to START.
- START: `TX_OUT`=0 for one cycle, then DATA.
- DATA: shifts out latched bits 0..DATA_WIDTH-1, LSB first, one per cycle. A bit counter runs 0..DATA_WIDTH-1 and is cleared on exit. After the last bit, the FSM goes to PARITY if the latched `PAR_EN`=1, otherwise to STOP.
- PARITY: drives one bit for one cycle, then STOP.
  - Even: the parity bit is the XOR-reduction of the latched word.
  - Odd: the parity bit is the inverse of the XOR-reduction.
- STOP: `TX_OUT`=1 for one cycle, then IDLE.
- `Busy`=1 in START, DATA, PARITY and STOP.
- `Data_Valid` outside IDLE is ignored. The request is dropped, not queued; upstream must wait for `Busy`=0.
- Changes to `P_DATA`, `PAR_EN` or `PAR_TYP` after acceptance have no effect on the frame in flight.
- Parity is computed from the latched word, never from the live `P_DATA`.

## Timing
- Reset: when `RST`=0 at a rising edge, the next state is IDLE, `TX_OUT`=1, `Busy`=0, and the bit counter and data register are cleared. This takes priority over everything, including mid-frame. A frame cut by reset is abandoned; there is no partial stop bit and the line returns high on that edge.
- Acceptance at edge N:
  - After edge N: start bit on `TX_OUT`, and `Busy`=1.
  - Data bit i occupies cycle N+1+i.
  - The parity bit, if enabled, occupies cycle N+1+DATA_WIDTH.
- Frame length is DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity.
- After the STOP cycle the state is IDLE and `Busy`=0, so the earliest next acceptance is the edge ending that first IDLE cycle.
- Minimum frame-to-frame spacing is one idle (high) cycle between stop and start.
- `TX_OUT` and `Busy` are flop outputs and glitch-free.
- No combinational path runs from any input to any output.

## Test plan
- Reset, then hold: `RST`=0 for 2 cycles then 1, with `Data_Valid`=0 -> `TX_OUT`=1 and `Busy`=0 indefinitely.
- No parity: `P_DATA`=0xA5, `PAR_EN`=0, strobe -> `TX_OUT` = 0,1,0,1,0,0,1,0,1,1 over 10 cycles, `Busy` high for exactly those 10 cycles, then 1/0.
- Even parity: `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0 -> parity bit 0, 11-cycle frame.
- Odd parity: the same word with `PAR_TYP`=1 -> parity bit 1. Also `P_DATA`=0x00 with odd parity -> parity bit 1.
- Ignored inputs mid-frame: strobe 0x3C, then in cycle 4 pulse `Data_Valid` with 0xFF and toggle `PAR_EN` -> the 0x3C frame is unchanged and no 0xFF frame follows.
- Back-to-back and reset: assert `Data_Valid` on the first IDLE cycle after a stop -> the next start bit follows exactly one high cycle later. Asserting `RST`=0 during data bit 3 -> `TX_OUT`=1 and `Busy`=0 after that edge, and the next accepted frame is complete and correct.
